// File: rtl/p_fetch.sv
// Instruction fetch sequencer: owns the PC, fetches words over req/ack and
// holds one instruction for the decoder until it is consumed.
//
// state   | meaning
// S_RST   | reset held or just released; no request, outputs at reset values
// S_FETCH | request outstanding at pc_q, waiting for ack
// S_HOLD  | instruction valid, waiting for an unstalled consume
module p_fetch #(
   parameter logic [31:0] P_RESET_PC = 32'h0000_0000
) (
   input  logic        P_clk,
   input  logic        P_reset,
   output logic        P_imem_req,
   output logic [31:0] P_imem_addr,
   input  logic        P_imem_ack,
   input  logic [31:0] P_imem_rdata,
   output logic [31:0] P_instruction,
   output logic        P_inst_valid,
   output logic [31:0] P_pc_out,
   input  logic        P_stall,
   input  logic        P_Branch,
   input  logic        P_zero
);

   localparam logic [31:0] RESET_PC_W = {P_RESET_PC[31:2], 2'b00};
   localparam logic [5:0]  OP_J       = 6'd2;

   typedef enum logic [1:0] {
      S_RST,
      S_FETCH,
      S_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;

   logic [31:0] pc4;
   logic [31:0] br_off;
   logic [31:0] pc_next;

   // Redirect is resolved combinationally from the held instruction so the
   // first FETCH cycle after consume already shows the correct target.
   always_comb begin
      pc4    = pc_out_q + 32'd4;
      br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      if (instr_q[31:26] == OP_J) begin
         pc_next = {pc4[31:28], instr_q[25:0], 2'b00};
      end else if (P_Branch && P_zero) begin
         pc_next = pc4 + br_off;
      end else begin
         pc_next = pc4;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      P_imem_req   = 1'b0;
      P_inst_valid = 1'b0;
      case (state_q)
         S_RST: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            P_imem_req = 1'b1;
            if (P_imem_ack) begin
               instr_d  = P_imem_rdata;
               pc_out_d = pc_q;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            P_inst_valid = 1'b1;
            if (!P_stall) begin
               pc_d    = pc_next;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_RST;
         end
      endcase
   end

   always_ff @(posedge P_clk) begin
      if (P_reset) begin
         state_q  <= S_RST;
         pc_q     <= RESET_PC_W;
         instr_q  <= 32'h0;
         pc_out_q <= RESET_PC_W;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
      end
   end

   // pc_q is forced to the reset PC by reset, so it doubles as the RST address.
   assign P_imem_addr   = pc_q;
   assign P_instruction = instr_q;
   assign P_pc_out      = pc_out_q;

endmodule

// File: doc/p_fetch.md
# P_fetch

Instruction fetch sequencer for the MIPS core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents one instruction at a time on `P_instruction` to the control decoder and datapath. On consumption it computes the next PC: sequential, taken-BEQ, or J. It resolves J itself from the held opcode and resolves BEQ from the decoder's `P_Branch` and the ALU's `P_zero`.

## Interface
- `P_RESET_PC`, default 32'h0000_0000: PC fetched first after reset. Bits [1:0] are forced to 0.
- `P_clk`, input, 1: the single clock. All state updates on the rising edge.
- `P_reset`, input, 1: synchronous, active-high reset.
- `P_imem_req`, output, 1: read request to instruction memory.
- `P_imem_addr`, output, 32: word-aligned read address. Stable while `P_imem_req` is high.
- `P_imem_ack`, input, 1: memory has returned data this cycle.
- `P_imem_rdata`, input, 32: instruction word, valid only when `P_imem_ack` is high.
- `P_instruction`, output, 32: held instruction, sent to the decoder and datapath.
- `P_inst_valid`, output, 1: `P_instruction` and `P_pc_out` are valid.
- `P_pc_out`, output, 32: PC of the held instruction.
- `P_stall`, input, 1: downstream is not ready to consume the held instruction.
- `P_Branch`, input, 1: from the decoder, qualifying the held instruction.
- `P_zero`, input, 1: ALU zero flag for the held instruction.

## Operation
- FSM states: RST, FETCH, HOLD.
- **RST** (entered when `P_reset` is high at an edge):
  - Outputs: `P_imem_req`=0, `P_inst_valid`=0, `P_instruction`=32'h0 (NOP), `P_pc_out`=`P_RESET_PC`, `P_imem_addr`=`P_RESET_PC`.
  - On the first edge with `P_reset` low, go to FETCH.
- **FETCH**:
  - `P_imem_req`=1, `P_imem_addr`=PC (the next-fetch register).
  - At an edge with `P_imem_ack`=1: latch `P_imem_rdata` into `P_instruction`, set `P_pc_out`=PC, go to HOLD.
- **HOLD**:
  - `P_imem_req`=0, `P_inst_valid`=1.
  - Consume event = `P_inst_valid` & ~`P_stall` at an edge. On consume: load PC with the next PC, clear `P_inst_valid`, go to FETCH.
  - While stalled, `P_instruction` and `P_pc_out` are frozen.
- **Next-PC priority**, evaluated on the held instruction, with pc4 = `P_pc_out` + 4:
  - Opcode [31:26] == 6'd2 (J): {pc4[31:28], instr[25:0], 2'b00}.
  - Else if `P_Branch` & `P_zero`: pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - Else pc4.
- Arithmetic is 32-bit modulo 2^32; no overflow detection. 32'hFFFF_FFFC + 4 wraps to 0.
- `P_Branch` and `P_zero` are sampled only at the consume edge. They are ignored in FETCH and while stalled.
- `P_imem_ack` is ignored in RST and HOLD. A stale ack after a reset never loads `P_instruction`.
- Memory must tolerate `P_imem_req` dropping without an ack, which happens only on reset.

## Timing
- Ack latency is L ≥ 0 cycles after `P_imem_req` rises. An ack in the same cycle `P_imem_req` rises is legal.
- `P_inst_valid` rises at the edge that samples the ack, so it is high the following cycle.
- With L=1 and no stall, one instruction is consumed every 3 cycles: FETCH, FETCH(ack), HOLD.
- The redirect is applied in the same cycle as consumption. `P_imem_addr` shows the new target on the first FETCH cycle; there is no wrong-path fetch.
- Reset wins over every other event in the same cycle, including ack and consume.
- Reset mid-FETCH: `P_imem_req` is 0 the cycle after the reset edge, and the fetch restarts at `P_RESET_PC`.

## Test plan
1. **Sequential fetch.** Reset with `P_RESET_PC`=0, ack L=1, no stall. Required: `P_imem_addr` = 0x0, 0x4, 0x8. Each `P_rdata` appears on `P_instruction` with `P_pc_out` matching its address, one cycle after its ack.
2. **Stall.** Hold `P_stall`=1 for 3 cycles in HOLD. Required: `P_instruction` and `P_pc_out` are unchanged, `P_imem_req`=0 throughout, and the next fetch starts the cycle after `P_stall` drops.
3. **BEQ.** Held 32'h1000_FFFF at PC 0x40, `P_Branch`=1.
   - With `P_zero`=1: next `P_imem_addr` = 0x40.
   - Repeat with `P_zero`=0: next address = 0x44.
   - Repeat held 32'h1000_0003 with a taken branch: next address = 0x50.
4. **J.** Held 32'h0800_0020 at PC 0x40. Required: next address = 0x80, independent of `P_Branch`/`P_zero`.
5. **Wrap.** Held 32'h0BFF_FFFF at PC 0xF000_0000. Required: next address = 0xFFFF_FFFC. Consuming that instruction (non-branch) gives next address = 0x0000_0000.
6. **Reset mid-fetch.**
   - Assert `P_reset` while `P_imem_req`=1 and before the ack. Pulse `P_imem_ack` during reset and on the cycle after reset releases.
   - Required: `P_inst_valid` stays 0 during reset. The first FETCH after reset drives `P_imem_addr`=`P_RESET_PC`. Only an ack sampled in FETCH loads `P_instruction`.
